// File: rtl/lif_layer.sv
// Time-multiplexed leaky integrate-and-fire layer. Neurons share one adder tree
// and are updated serially, one per clock, after each input sample is captured.
module lif_layer #(
    parameter int N_IN       = 32'd4,
    parameter int N_OUT      = 32'd2,
    parameter int W_BITS     = 32'd8,
    parameter int V_BITS     = 32'd16,
    parameter int THRESH     = 32'd64,
    parameter int LEAK_SHIFT = 32'd3,
    parameter int N_CYCLES   = 32'd10,
    parameter int CNT_BITS   = 32'd5,
    parameter int RESET_MODE = 32'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sample_ready,
    output logic                          ready,
    output logic                          sample,
    input  logic [N_IN-1:0]               in_spikes,
    output logic [N_OUT-1:0]              out_spikes,
    output logic                          out_valid,
    output logic [N_OUT*CNT_BITS-1:0]     spike_cnt,
    output logic                          done,
    input  logic                          w_we,
    input  logic [$clog2(N_IN*N_OUT)-1:0] w_addr,
    input  logic [W_BITS-1:0]             w_data
);

    localparam int AW    = $clog2(N_IN * N_OUT);
    localparam int JW    = (N_OUT > 32'd1) ? $clog2(N_OUT) : 32'd1;
    localparam int ACC_W = V_BITS + $clog2(N_IN) + 32'd1;

    localparam logic signed [ACC_W-1:0]  ACC_MAX  = ACC_W'((32'sd1 <<< (V_BITS - 32'd1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = ACC_W'(-(32'sd1 <<< (V_BITS - 32'd1)));
    localparam logic signed [V_BITS-1:0] THRESH_V = V_BITS'(THRESH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_UPDATE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    next_state_s;
    logic [JW-1:0]             nrn_r;
    logic [CNT_BITS-1:0]       ts_r;
    logic [N_IN-1:0]           in_reg_r;
    logic [N_OUT-1:0]          shadow_r;
    logic [N_OUT-1:0]          shadow_next_s;
    logic [N_OUT-1:0]          out_spikes_r;
    logic                      out_valid_r;
    logic                      done_r;
    logic                      ready_r;
    logic signed [W_BITS-1:0]  weights_r [N_OUT][N_IN];
    logic signed [V_BITS-1:0]  mem_r [N_OUT];
    logic [CNT_BITS-1:0]       cnt_r [N_OUT];

    logic                      start_ok_s;
    logic                      wr_ok_s;
    logic signed [V_BITS-1:0]  mem_cur_s;
    logic signed [ACC_W-1:0]   sum_s;
    logic signed [ACC_W-1:0]   acc_s;
    logic signed [V_BITS-1:0]  sat_s;
    logic signed [V_BITS-1:0]  mem_next_s;
    logic                      fire_s;
    logic                      last_nrn_s;
    logic                      last_ts_s;

    // Clamp the wide accumulator back into the membrane range.
    function automatic logic signed [V_BITS-1:0] sat_v(input logic signed [ACC_W-1:0] a);
        logic signed [V_BITS-1:0] r;
        if (a > ACC_MAX) begin
            r = V_BITS'(ACC_MAX);
        end else if (a < ACC_MIN) begin
            r = V_BITS'(ACC_MIN);
        end else begin
            r = V_BITS'(a);
        end
        return r;
    endfunction

    // ready only goes high one edge after reset release, so it gates start and writes.
    assign start_ok_s = (state_r == ST_IDLE) && ready_r && start;
    assign wr_ok_s    = (state_r == ST_IDLE) && ready_r && w_we;
    assign last_nrn_s = (nrn_r == JW'(N_OUT - 32'd1));
    assign last_ts_s  = (ts_r == CNT_BITS'(N_CYCLES - 32'd1));

    assign ready      = ready_r;
    assign sample     = (state_r == ST_SAMPLE) && sample_ready;
    assign out_spikes = out_spikes_r;
    assign out_valid  = out_valid_r;
    assign done       = done_r;

    for (genvar gj = 0; gj < N_OUT; gj++) begin : g_cnt
        assign spike_cnt[gj*CNT_BITS +: CNT_BITS] = cnt_r[gj];
    end

    // Membrane update datapath for the neuron currently selected by nrn_r.
    always_comb begin
        mem_cur_s = mem_r[nrn_r];
        sum_s     = '0;
        for (int i = 32'sd0; i < N_IN; i++) begin
            if (in_reg_r[i]) begin
                sum_s = sum_s + ACC_W'(weights_r[nrn_r][i]);
            end else begin
                sum_s = sum_s;
            end
        end
        acc_s  = ACC_W'(mem_cur_s) - ACC_W'(mem_cur_s >>> LEAK_SHIFT) + sum_s;
        sat_s  = sat_v(acc_s);
        fire_s = (sat_s >= THRESH_V);
        if (fire_s) begin
            if (RESET_MODE == 32'd1) begin
                mem_next_s = sat_s - THRESH_V;
            end else begin
                mem_next_s = '0;
            end
        end else begin
            mem_next_s = sat_s;
        end
        shadow_next_s        = shadow_r;
        shadow_next_s[nrn_r] = fire_s;
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) next_state_s = ST_SAMPLE;
                else            next_state_s = ST_IDLE;
            end
            ST_SAMPLE: begin
                if (sample_ready) next_state_s = ST_UPDATE;
                else              next_state_s = ST_SAMPLE;
            end
            ST_UPDATE: begin
                if (last_nrn_s) next_state_s = ST_EMIT;
                else            next_state_s = ST_UPDATE;
            end
            ST_EMIT: begin
                if (last_ts_s) next_state_s = ST_DONE;
                else           next_state_s = ST_SAMPLE;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Weight memory: written only while idle, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 32'sd0; j < N_OUT; j++) begin
                for (int i = 32'sd0; i < N_IN; i++) begin
                    weights_r[j][i] <= '0;
                end
            end
        end else begin
            for (int j = 32'sd0; j < N_OUT; j++) begin
                for (int i = 32'sd0; i < N_IN; i++) begin
                    if (wr_ok_s && (w_addr == AW'(j * N_IN + i))) begin
                        weights_r[j][i] <= w_data;
                    end
                end
            end
        end
    end

    // FSM state, neuron state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            nrn_r        <= '0;
            ts_r         <= '0;
            in_reg_r     <= '0;
            shadow_r     <= '0;
            out_spikes_r <= '0;
            out_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            for (int j = 32'sd0; j < N_OUT; j++) begin
                mem_r[j] <= '0;
                cnt_r[j] <= '0;
            end
        end else begin
            state_r     <= next_state_s;
            ready_r     <= (next_state_s == ST_IDLE);
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        ts_r         <= '0;
                        out_spikes_r <= '0;
                        for (int j = 32'sd0; j < N_OUT; j++) begin
                            mem_r[j] <= '0;
                            cnt_r[j] <= '0;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (sample_ready) begin
                        in_reg_r <= in_spikes;
                        nrn_r    <= '0;
                    end
                end
                ST_UPDATE: begin
                    mem_r[nrn_r] <= mem_next_s;
                    shadow_r     <= shadow_next_s;
                    nrn_r        <= nrn_r + JW'(1);
                    if (fire_s && (cnt_r[nrn_r] != '1)) begin
                        cnt_r[nrn_r] <= cnt_r[nrn_r] + CNT_BITS'(1);
                    end
                    // Publish on the edge into EMIT so out_spikes is valid alongside out_valid.
                    if (last_nrn_s) begin
                        out_spikes_r <= shadow_next_s;
                        out_valid_r  <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    ts_r <= ts_r + CNT_BITS'(1);
                    if (last_ts_s) begin
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Directed and randomized bench for lif_layer: two instances (reset-to-zero and
// subtract-threshold) share all inputs and are compared against an arithmetic model.
module tb_lif_layer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sample_ready;
    logic [3:0] in_spikes;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;

    logic       ready0, sample0, out_valid0, done0;
    logic [1:0] out_spikes0;
    logic [9:0] spike_cnt0;
    logic       ready1, sample1, out_valid1, done1;
    logic [1:0] out_spikes1;
    logic [9:0] spike_cnt1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // reference model state: weights, membranes and counts per mode
    int         w_m [2][4];
    int         v_m [2][2];
    int         c_m [2][2];
    logic [3:0] spk_tab [10];
    int         stall_tab [10];

    lif_layer #(.RESET_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_ready(sample_ready),
        .ready(ready0), .sample(sample0), .in_spikes(in_spikes),
        .out_spikes(out_spikes0), .out_valid(out_valid0), .spike_cnt(spike_cnt0),
        .done(done0), .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
    );

    lif_layer #(.RESET_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_ready(sample_ready),
        .ready(ready1), .sample(sample1), .in_spikes(in_spikes),
        .out_spikes(out_spikes1), .out_valid(out_valid1), .spike_cnt(spike_cnt1),
        .done(done1), .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_cnt();
        return {5'(c_m[0][1]), 5'(c_m[0][0]), 5'(c_m[1][1]), 5'(c_m[1][0])};
    endfunction

    // One timestep of the layer computed straight from the neuron equations.
    task automatic model_step(input logic [3:0] spk, output logic [1:0] s0, output logic [1:0] s1);
        logic [1:0] s [2];
        for (int m = 0; m < 2; m++) begin
            s[m] = 2'b00;
            for (int j = 0; j < 2; j++) begin
                int acc;
                acc = v_m[m][j] - (v_m[m][j] >>> 3);
                for (int i = 0; i < 4; i++) if (spk[i]) acc += w_m[j][i];
                if (acc > 32767) acc = 32767;
                else if (acc < -32768) acc = -32768;
                if (acc >= 64) begin
                    s[m][j] = 1'b1;
                    if (c_m[m][j] < 31) c_m[m][j]++;
                    v_m[m][j] = (m == 1) ? acc - 64 : 0;
                end else begin
                    v_m[m][j] = acc;
                end
            end
        end
        s0 = s[0];
        s1 = s[1];
    endtask

    // Check this cycle's registered flags, drive inputs, check sample, advance a clock.
    task automatic step(input logic sr, input logic [3:0] spk,
                        input logic ev, input logic ed, input logic er, input logic es);
        check("flags", {out_valid0, done0, ready0, out_valid1, done1, ready1},
              {ev, ed, er, ev, ed, er});
        sample_ready = sr;
        in_spikes    = spk;
        #1;
        check("sample", {sample0, sample1}, {es, es});
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int j, input int i, input int val);
        w_we   = 1'b1;
        w_addr = 3'(j * 4 + i);
        w_data = 8'(val);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        w_we = 1'b0;
        w_m[j][i] = val;
    endtask

    task automatic run_inf(input int abort_ts, input bit busy);
        logic [1:0] s0, s1;
        start = 1'b1;
        step(1'b0, 4'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < 2; j++) begin
                v_m[m][j] = 0;
                c_m[m][j] = 0;
            end
        for (int t = 0; t < 10; t++) begin
            if (t == abort_ts) begin
                rst_n = 1'b0;
                step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                check("mid_reset_outs",
                      {out_spikes0, spike_cnt0, out_valid0, done0, ready0, sample0,
                       out_spikes1, spike_cnt1, out_valid1, done1, ready1, sample1}, 64'd0);
                rst_n = 1'b1;
                step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int j = 0; j < 2; j++)
                    for (int i = 0; i < 4; i++) w_m[j][i] = 0;
                return;
            end
            for (int s = 0; s < stall_tab[t]; s++)
                step(1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, spk_tab[t], 1'b0, 1'b0, 1'b0, 1'b1);
            model_step(spk_tab[t], s0, s1);
            for (int j = 0; j < 2; j++) begin
                if (busy && t == 2 && j == 0) begin
                    w_we   = 1'b1;
                    w_addr = 3'd0;
                    w_data = 8'h80;
                    start  = 1'b1;
                end
                step(1'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                w_we  = 1'b0;
                start = 1'b0;
            end
            check("out_spikes", {out_spikes0, out_spikes1}, {s0, s1});
            check("spike_cnt", {spike_cnt0, spike_cnt1}, exp_cnt());
            step(1'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'($urandom), 4'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        check("cnt_hold", {spike_cnt0, spike_cnt1}, exp_cnt());
    endtask

    task automatic fill_tabs(input logic [3:0] spk, input int stall_at, input int stall_len);
        for (int t = 0; t < 10; t++) begin
            spk_tab[t]   = spk;
            stall_tab[t] = (t == stall_at) ? stall_len : 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sample_ready = 1'b0; in_spikes = 4'd0;
        w_we = 1'b0; w_addr = 3'd0; w_data = 8'd0;
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < 2; j++) begin
                v_m[m][j] = 0;
                c_m[m][j] = 0;
                for (int i = 0; i < 4; i++) w_m[j][i] = 0;
            end

        // reset held three edges: every output low
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_outs",
                  {out_spikes0, spike_cnt0, out_valid0, done0, ready0, sample0,
                   out_spikes1, spike_cnt1, out_valid1, done1, ready1, sample1}, 64'd0);
        end
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // basic fire: neuron 0 crosses threshold every timestep
        for (int i = 0; i < 4; i++) write_w(0, i, 40);
        fill_tabs(4'hF, -1, 0);
        run_inf(-1, 1'b0);
        check("basic_cnt_m0", 64'(spike_cnt0), 64'h00A);
        check("basic_cnt_m1", 64'(spike_cnt1), 64'h00A);

        // writes and start during UPDATE must be ignored
        run_inf(-1, 1'b1);
        check("busy_cnt_m0", 64'(spike_cnt0), 64'h00A);

        // leak and integration with a single active input
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) write_w(j, i, (j == 0 && i == 0) ? 20 : 0);
        fill_tabs(4'h1, -1, 0);
        run_inf(-1, 1'b0);
        check("leak_cnt_m0", 64'(spike_cnt0), 64'h002);
        check("leak_cnt_m1", 64'(spike_cnt1), 64'h002);

        // five-cycle input stall before the third timestep
        fill_tabs(4'h1, 2, 5);
        run_inf(-1, 1'b0);

        // randomized weights, spikes and stalls
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 4; i++) begin
                    byte b;
                    b = byte'($urandom);
                    write_w(j, i, int'(b));
                end
            for (int t = 0; t < 10; t++) begin
                spk_tab[t]   = 4'($urandom);
                stall_tab[t] = int'($urandom_range(0, 2));
            end
            run_inf(-1, 1'b0);
        end

        // reset during timestep 5, then a run that must see zeroed weights
        fill_tabs(4'hF, -1, 0);
        run_inf(5, 1'b0);
        run_inf(-1, 1'b0);
        check("post_reset_cnt", {spike_cnt0, spike_cnt1}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
